// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port instruction/data memory between
// the fetch and access stages. Data has fixed priority; a starvation counter
// lets fetch win a tie after STARVE_MAX consecutive data grants. One
// outstanding transaction; flushed fetches are aborted or their response dropped.
// All outputs are registered.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // fetch port
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  input  logic              i_if_flush,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  // data port
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [3:0]        i_dm_be,
  input  logic [31:0]       i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_gnt,
  output logic              o_dm_rvalid,
  output logic [DATA_W-1:0] o_dm_rdata,
  // memory port
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [31:0]       o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  // status
  output logic              o_arb_busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ_I  = 3'd1;
  localparam logic [2:0] S_REQ_D  = 3'd2;
  localparam logic [2:0] S_WAIT_I = 3'd3;
  localparam logic [2:0] S_WAIT_D = 3'd4;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [3:0]        r_starve_cnt;
  logic              r_drop;
  logic              r_if_gnt;
  logic              r_dm_gnt;
  logic              r_if_rvalid;
  logic              r_dm_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;

  logic w_idle;
  logic w_starved;
  logic w_if_ok;
  logic w_grant_i;
  logic w_grant_d;
  logic w_if_resp;
  logic w_dm_resp;

  // Arbitration: only in IDLE; a flush in the same cycle blocks the fetch grant.
  assign w_idle    = (r_state == S_IDLE);
  assign w_starved = (r_starve_cnt == STARVE_LIM);
  assign w_if_ok   = i_if_req && !i_if_flush;
  assign w_grant_i = w_idle && w_if_ok && (!i_dm_req || w_starved);
  assign w_grant_d = w_idle && i_dm_req && !w_grant_i;

  // A fetch response is delivered only if no flush hit it (earlier or now).
  assign w_if_resp = (r_state == S_WAIT_I) && i_mem_rvalid && !r_drop && !i_if_flush;
  assign w_dm_resp = (r_state == S_WAIT_D) && i_mem_rvalid;

  // Next-state decode for the single-transaction FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_i)      w_state_nxt = S_REQ_I;
        else if (w_grant_d) w_state_nxt = S_REQ_D;
      end
      S_REQ_I: begin
        // A flush normally aborts the request. If the memory accepts in the
        // same cycle, a response is still coming, so wait for it and drop it.
        if (i_mem_ready)     w_state_nxt = S_WAIT_I;
        else if (i_if_flush) w_state_nxt = S_IDLE;
      end
      S_REQ_D: begin
        if (i_mem_ready) w_state_nxt = S_WAIT_D;
      end
      S_WAIT_I, S_WAIT_D: begin
        if (i_mem_rvalid) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, busy flag, request line and grant pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_mem_req <= 1'b0;
      r_if_gnt  <= 1'b0;
      r_dm_gnt  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_mem_req <= (w_state_nxt == S_REQ_I) || (w_state_nxt == S_REQ_D);
      r_if_gnt  <= w_grant_i;
      r_dm_gnt  <= w_grant_d;
    end
  end

  // Latch the winning request into the memory-side registers on the grant edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= '0;
    end else if (w_grant_i) begin
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'hF;
      r_mem_addr  <= i_if_addr;
      r_mem_wdata <= '0;
    end else if (w_grant_d) begin
      r_mem_we    <= i_dm_we;
      r_mem_be    <= i_dm_we ? i_dm_be : 4'hF;
      r_mem_addr  <= i_dm_addr;
      r_mem_wdata <= i_dm_we ? i_dm_wdata : '0;
    end
  end

  // Response pulses and read-data capture; stores report zero data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= w_if_resp;
      r_dm_rvalid <= w_dm_resp;
      if (w_if_resp) r_if_rdata <= i_mem_rdata;
      if (w_dm_resp) r_dm_rdata <= r_mem_we ? '0 : i_mem_rdata;
    end
  end

  // Starvation counter: counts data wins over a waiting fetch, saturating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= 4'h0;
    end else if (w_grant_i) begin
      r_starve_cnt <= 4'h0;
    end else if (w_grant_d && i_if_req) begin
      if (!w_starved) r_starve_cnt <= r_starve_cnt + 4'h1;
    end else if (w_idle && !i_if_req) begin
      r_starve_cnt <= 4'h0;
    end
  end

  // Drop flag: remembers that the in-flight fetch was flushed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop <= 1'b0;
    end else if (w_grant_i) begin
      r_drop <= 1'b0;
    end else if (r_state == S_REQ_I) begin
      if (i_if_flush && i_mem_ready) r_drop <= 1'b1;
    end else if (r_state == S_WAIT_I) begin
      if (i_mem_rvalid)    r_drop <= 1'b0;
      else if (i_if_flush) r_drop <= 1'b1;
    end
  end

  assign o_if_gnt    = r_if_gnt;
  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_gnt    = r_dm_gnt;
  assign o_dm_rvalid = r_dm_rvalid;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_arb_busy  = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grant and
// response events; a monitor pops and compares on every grant/rvalid pulse.
module tb_mem_port_arbiter;

  localparam logic [1:0] K_GI = 2'd0;
  localparam logic [1:0] K_GD = 2'd1;
  localparam logic [1:0] K_RI = 2'd2;
  localparam logic [1:0] K_RD = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        i_if_flush;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_dm_req;
  logic        i_dm_we;
  logic [3:0]  i_dm_be;
  logic [31:0] i_dm_addr;
  logic [31:0] i_dm_wdata;
  logic        o_dm_gnt;
  logic        o_dm_rvalid;
  logic [31:0] o_dm_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_arb_busy;

  int          n_cmp;
  int          n_err;
  ev_t         sb[$];

  int          mem_rv_delay;
  logic        mem_fixed_en;
  logic [31:0] mem_fixed_val;

  logic [138:0] all_out;
  assign all_out = {o_if_gnt, o_if_rvalid, o_if_rdata, o_dm_gnt, o_dm_rvalid,
                    o_dm_rdata, o_mem_req, o_mem_we, o_mem_be, o_mem_addr,
                    o_mem_wdata, o_arb_busy};

  mem_port_arbiter #(.STARVE_MAX(3), .DATA_W(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_if_req     (i_if_req),
    .i_if_addr    (i_if_addr),
    .i_if_flush   (i_if_flush),
    .o_if_gnt     (o_if_gnt),
    .o_if_rvalid  (o_if_rvalid),
    .o_if_rdata   (o_if_rdata),
    .i_dm_req     (i_dm_req),
    .i_dm_we      (i_dm_we),
    .i_dm_be      (i_dm_be),
    .i_dm_addr    (i_dm_addr),
    .i_dm_wdata   (i_dm_wdata),
    .o_dm_gnt     (o_dm_gnt),
    .o_dm_rvalid  (o_dm_rvalid),
    .o_dm_rdata   (o_dm_rdata),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_be     (o_mem_be),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ready  (i_mem_ready),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_arb_busy   (o_arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data returned by the memory model for a load/fetch at address a.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [1:0] k, input logic [31:0] d);
    ev_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL sb_unexpected: got event kind %0d data %h, expected no event", k, d);
    end else begin
      e = sb.pop_front();
      if (e.kind !== k || e.data !== d) begin
        n_err++;
        $display("FAIL sb_event: got kind %0d data %h expected kind %0d data %h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic want_if, input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (want_if ? o_if_gnt : o_dm_gnt) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: got no grant within 40 cycles, expected a grant", name);
    end
  endtask

  task automatic wait_idle(input string name);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (!o_arb_busy) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: got arb_busy stuck high for 40 cycles, expected idle", name);
    end
  endtask

  // Memory model: accepts on req&&ready, answers mem_rv_delay cycles later.
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    logic        pwe;
    pend = 1'b0;
    cnt = 0;
    paddr = 32'h0;
    pwe = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else if (!pend && o_mem_req && i_mem_ready) begin
        pend = 1'b1;
        cnt = mem_rv_delay;
        paddr = o_mem_addr;
        pwe = o_mem_we;
      end
      @(posedge clk);
      #1;
      i_mem_rvalid = 1'b0;
      i_mem_rdata = 32'h0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata = pwe ? 32'hFFFF_FFFF : (mem_fixed_en ? mem_fixed_val : mem_fn(paddr));
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: every grant or response pulse must match the next expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (o_if_gnt)    sb_check(K_GI, o_mem_addr);
      if (o_dm_gnt)    sb_check(K_GD, o_mem_addr);
      if (o_if_rvalid) sb_check(K_RI, o_if_rdata);
      if (o_dm_rvalid) sb_check(K_RD, o_dm_rdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at 500000, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ng;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    i_if_req = 1'b0;
    i_if_addr = 32'h0;
    i_if_flush = 1'b0;
    i_dm_req = 1'b0;
    i_dm_we = 1'b0;
    i_dm_be = 4'h0;
    i_dm_addr = 32'h0;
    i_dm_wdata = 32'h0;
    i_mem_ready = 1'b0;
    mem_rv_delay = 0;
    mem_fixed_en = 1'b0;
    mem_fixed_val = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 160'(all_out), 160'(0));
    step;
    rst_n = 1'b1;
    i_mem_ready = 1'b1;
    step;
    step;

    // Single load, zero-wait memory: gnt N+1, rvalid N+3, idle N+3
    mem_fixed_en = 1'b1;
    mem_fixed_val = 32'hDEAD_BEEF;
    push(K_GD, 32'h0000_0100);
    push(K_RD, 32'hDEAD_BEEF);
    i_dm_req = 1'b1;
    i_dm_we = 1'b0;
    i_dm_be = 4'h0;
    i_dm_addr = 32'h0000_0100;
    @(negedge clk);
    chk("load_no_early_gnt", 160'(o_dm_gnt), 160'(0));
    @(negedge clk);
    chk("load_gnt", 160'({o_dm_gnt, o_mem_req, o_mem_we, o_mem_be}), 160'({1'b1, 1'b1, 1'b0, 4'hF}));
    step;
    i_dm_req = 1'b0;
    @(negedge clk);
    chk("load_wait", 160'({o_arb_busy, o_mem_req}), 160'(2'b10));
    @(negedge clk);
    chk("load_rvalid", 160'({o_dm_rvalid, o_arb_busy, o_dm_rdata}), 160'({1'b1, 1'b0, 32'hDEAD_BEEF}));
    step;
    mem_fixed_en = 1'b0;

    // Store with a stalled memory: mem_* held stable, dm_rdata = 0
    i_mem_ready = 1'b0;
    push(K_GD, 32'h0000_0200);
    push(K_RD, 32'h0000_0000);
    i_dm_req = 1'b1;
    i_dm_we = 1'b1;
    i_dm_be = 4'b0011;
    i_dm_addr = 32'h0000_0200;
    i_dm_wdata = 32'h0000_1234;
    wait_gnt(1'b0, "store_gnt");
    chk("store_mem", 160'({o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata}),
        160'({1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'h0000_1234}));
    step;
    i_dm_req = 1'b0;
    i_dm_we = 1'b0;
    i_dm_be = 4'h0;
    i_dm_wdata = 32'h0;
    @(negedge clk);
    chk("store_hold", 160'({o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata}),
        160'({1'b1, 1'b1, 4'b0011, 32'h0000_0200, 32'h0000_1234}));
    step;
    i_mem_ready = 1'b1;
    wait_idle("store_idle");
    step;

    // Priority and starvation: order D,D,D,I,D,D,D,I
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) begin
        push(K_GI, 32'h0000_1000);
        push(K_RI, 32'h5A5A_1000);
      end else begin
        push(K_GD, 32'h0000_2000);
        push(K_RD, 32'h5A5A_2000);
      end
    end
    i_if_req = 1'b1;
    i_if_addr = 32'h0000_1000;
    i_dm_req = 1'b1;
    i_dm_addr = 32'h0000_2000;
    ng = 0;
    for (int k = 0; k < 100 && ng < 8; k++) begin
      @(negedge clk);
      if (o_if_gnt || o_dm_gnt) ng++;
    end
    chk("starve_grants", 160'(ng), 160'(8));
    step;
    i_if_req = 1'b0;
    i_dm_req = 1'b0;
    wait_idle("starve_idle");
    step;

    // Flush while in REQ_I: request aborted, no if_rvalid
    i_mem_ready = 1'b0;
    push(K_GI, 32'h0000_3000);
    i_if_req = 1'b1;
    i_if_addr = 32'h0000_3000;
    wait_gnt(1'b1, "flushreq_gnt");
    step;
    i_if_req = 1'b0;
    i_if_flush = 1'b1;
    @(negedge clk);
    chk("flushreq_pending", 160'(o_mem_req), 160'(1));
    step;
    i_if_flush = 1'b0;
    @(negedge clk);
    chk("flushreq_abort", 160'({o_mem_req, o_arb_busy}), 160'(2'b00));
    i_mem_ready = 1'b1;
    repeat (4) step;

    // Flush while in WAIT_I: response dropped, pending data granted next
    mem_rv_delay = 2;
    mem_fixed_en = 1'b1;
    mem_fixed_val = 32'hCAFE_F00D;
    push(K_GI, 32'h0000_4000);
    push(K_GD, 32'h0000_5000);
    push(K_RD, 32'hCAFE_F00D);
    i_if_req = 1'b1;
    i_if_addr = 32'h0000_4000;
    wait_gnt(1'b1, "flushwait_gnt");
    step;
    i_if_req = 1'b0;
    i_if_flush = 1'b1;
    i_dm_req = 1'b1;
    i_dm_we = 1'b0;
    i_dm_addr = 32'h0000_5000;
    step;
    i_if_flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("flushwait_busy", 160'(o_arb_busy), 160'(1));
    @(negedge clk);
    chk("flushwait_drop", 160'({o_if_rvalid, o_arb_busy, o_if_rdata}), 160'({1'b0, 1'b0, 32'h5A5A_1000}));
    @(negedge clk);
    chk("flushwait_dgnt", 160'(o_dm_gnt), 160'(1));
    step;
    i_dm_req = 1'b0;
    wait_idle("flushwait_idle");
    step;
    mem_rv_delay = 0;
    mem_fixed_en = 1'b0;

    // Async reset in WAIT_D between edges, then a normal fetch
    mem_rv_delay = 3;
    push(K_GD, 32'h0000_6000);
    i_dm_req = 1'b1;
    i_dm_addr = 32'h0000_6000;
    wait_gnt(1'b0, "rst_dgnt");
    step;
    i_dm_req = 1'b0;
    @(negedge clk);
    chk("rst_pre_busy", 160'(o_arb_busy), 160'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 160'(all_out), 160'(0));
    step;
    step;
    @(negedge clk);
    rst_n = 1'b1;
    mem_rv_delay = 0;
    push(K_GI, 32'h0000_7000);
    push(K_RI, 32'h5A5A_7000);
    step;
    i_if_req = 1'b1;
    i_if_addr = 32'h0000_7000;
    wait_gnt(1'b1, "post_rst_gnt");
    chk("post_rst_fetch_mem", 160'({o_mem_req, o_mem_we, o_mem_be}), 160'({1'b1, 1'b0, 4'hF}));
    step;
    i_if_req = 1'b0;
    wait_idle("post_rst_idle");
    repeat (3) step;

    chk("sb_drain", 160'(sb.size()), 160'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified instruction/data memory between the fetch stage and the access stage of the rv32 pipeline. Data requests have fixed priority, and a starvation counter guarantees fetch progress. The block allows one outstanding transaction and drops in-flight fetches killed by a branch/jump flush. Every output is registered.

## Interface
- STARVE_MAX, 3: consecutive data grants allowed while fetch waits; then fetch wins the next tie (range 1–15).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  32  fetch word address.
- if_flush  in  1  one-cycle pulse; kills the pending/in-flight fetch.
- if_gnt  out  1  one-cycle pulse; fetch accepted.
- if_rvalid  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  32  fetched instruction.
- dm_req  in  1  data request; held until dm_gnt.
- dm_we  in  1  1 = store.
- dm_be  in  4  store byte enables.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_gnt  out  1  one-cycle pulse; data accepted.
- dm_rvalid  out  1  one-cycle pulse; load data valid or store done.
- dm_rdata  out  32  load data; 0 for stores.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  memory write.
- mem_be  out  4  byte enables; 4'hF for fetch and loads.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  write data.
- mem_ready  in  1  memory accepts mem_req this cycle.
- mem_rvalid  in  1  response pulse, at least 1 cycle after accept; also sent for writes.
- mem_rdata  in  32  read data.
- arb_busy  out  1  a transaction is outstanding.

## Operation
- States:
  - IDLE: no transaction.
  - REQ_I / REQ_D: mem_req high, waiting for mem_ready.
  - WAIT_I / WAIT_D: accepted, waiting for mem_rvalid.
- IDLE arbitration uses the sampled if_req, dm_req and if_flush.
  - Only dm_req: grant data.
  - Only if_req and no if_flush: grant fetch.
  - Both requesting: grant data, unless starve_cnt == STARVE_MAX; then grant fetch.
  - A fetch request is not granted in a cycle where if_flush is high.
- Grant edge:
  - Pulse x_gnt for one cycle.
  - Latch address, we, be and wdata into the mem_* registers; raise mem_req.
  - Go to REQ_x.
- starve_cnt (4 bits):
  - +1 on each data grant issued while if_req was high; saturates at STARVE_MAX.
  - Clears on any fetch grant, or in any IDLE cycle with if_req low.
- REQ_x to WAIT_x on the edge where mem_req && mem_ready; mem_req drops.
- WAIT_x to IDLE on mem_rvalid.
  - Pulse x_rvalid next cycle; register x_rdata = mem_rdata.
  - For stores, dm_rdata = 0.
- Flush handling:
  - In REQ_I: abort; mem_req low next cycle; go to IDLE; no if_rvalid.
  - In WAIT_I: set the drop flag; on mem_rvalid go to IDLE and suppress if_rvalid. if_rdata is not updated.
  - In any data state, or IDLE with no fetch in flight: no effect beyond blocking that cycle's fetch grant.
- A mem_rvalid received in IDLE or a REQ state is ignored.
- arb_busy = 1 in every state except IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; starve_cnt 0; drop flag 0. Reset mid-transaction abandons it. The memory is reset by the same rst.
- Request sampled in IDLE at cycle N:
  - x_gnt and mem_req high in N+1.
  - With mem_ready in N+1 and mem_rvalid in N+2, x_rvalid is high in N+3.
  - The block is IDLE in N+3 and can issue the next grant in N+4.
- Arbitration happens only in IDLE, so at most one grant per transaction. Requests arriving while busy wait.
- if_gnt and dm_gnt are never high in the same cycle. Neither are if_rvalid and dm_rvalid.
- mem_* outputs hold stable while mem_req is high.

## Test plan
- Single load: dm_req=1, dm_addr=0x100 at N; mem_ready in N+1; mem_rvalid with rdata 0xDEADBEEF in N+2 -> dm_gnt in N+1, dm_rvalid=1 and dm_rdata=0xDEADBEEF in N+3, arb_busy low in N+3.
- Priority and starvation (STARVE_MAX=3): if_req and dm_req held continuously with a zero-wait memory -> grant order D,D,D,I,D,D,D,I; starve_cnt returns to 0 after each fetch grant.
- Store: dm_we=1, dm_be=4'b0011, dm_wdata=0x1234 -> mem_we=1 and mem_be=4'b0011 while mem_req is high; dm_rvalid pulses with dm_rdata=0.
- Flush in REQ_I: mem_ready held low; if_flush pulses the cycle after if_gnt -> mem_req low the next cycle, IDLE, no if_rvalid ever.
- Flush in WAIT_I: if_flush after accept; mem_rvalid with 0xCAFEF00D -> if_rvalid stays 0, if_rdata unchanged; a pending dm_req is granted the cycle after return to IDLE.
- Async reset asserted mid-WAIT_D, between clock edges -> all outputs 0 immediately, no dm_rvalid; after release, a new if_req is granted normally.
